pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive side of the LED PWM interface: samples an external or looped-back PWM waveform and measures its period and high time in clk cycles.
- Publishes each completed period with a one-cycle valid strobe and flags a stuck (non-toggling) input.
- Used to self-check the LED drivers' PWM outputs and to read PWM-style sensor/servo inputs.

Parameters:
- W, 16, width of the cycle counter and of the period/high_time outputs.
- SYNC_STAGES, 2, synchronizer flops on pwm_in (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  capture enable
- pwm_in  in  1  asynchronous PWM input
- period  out  W  cycles from a rising edge to the next rising edge
- high_time  out  W  cycles pwm_in was high within that period
- valid  out  1  one-cycle strobe when period/high_time update
- stuck  out  1  no edge seen for 2^W-1 cycles
- level  out  1  synchronized pwm_in level (meaningful while stuck)

Behaviour:
- Reset (rst=0, async): period=0, high_time=0, valid=0, stuck=0, level=0; counter=0; sync flops=0; state=WAIT_RISE.
- Sync/edge: pwm_in passes through SYNC_STAGES flops to s; one further flop holds s_d. rise = s & ~s_d, fall = ~s & s_d.
- States:
  - WAIT_RISE: the first partial period is discarded. On rise: cnt<=1, go to MEAS_HIGH.
  - MEAS_HIGH: cnt increments each cycle. On fall: hcap<=cnt, go to MEAS_LOW.
  - MEAS_LOW: cnt increments. On rise: period<=cnt, high_time<=hcap, valid<=1, cnt<=1, go to MEAS_HIGH.
- Counting: the rise-detect cycle counts as cycle 1. A clock-aligned input high 4 cycles / low 6 cycles yields high_time=4, period=10.
- Latency: valid asserts on the 3rd clk rising edge after pwm_in rises (SYNC_STAGES=2). It is high for exactly one cycle.
- Saturation:
  - If cnt reaches 2^W-1 in MEAS_HIGH, MEAS_LOW or WAIT_RISE without the awaited edge: go to STUCK, stuck<=1, no valid pulse.
  - period and high_time hold their last values.
- STUCK:
  - level tracks s every cycle.
  - On rise: stuck<=0, cnt<=1, go to MEAS_HIGH. The next full period then produces valid.
  - Outside STUCK, level also tracks s.
- en=0: state<=WAIT_RISE, cnt<=0, valid<=0, stuck<=0. period and high_time hold. Sync flops keep running. On re-enable the first partial period is discarded.
- Simultaneous events:
  - rise cannot coincide with fall.
  - Saturation and an edge in the same cycle: the edge wins.
  - en=0 overrides everything.
- Reset mid-measurement: everything returns to reset values immediately; no valid is issued.
- Duty 0% or 100%: never completes a period, so the block ends in STUCK with level=0 or level=1.

Optional Feature:
- Macro PWM_GLITCH_FILTER_EN.
- Defined:
  - A new level is accepted only after s holds it for 2 consecutive cycles; rise/fall are computed on the filtered level.
  - Pulses of 1 cycle are ignored.
  - Latency becomes 4 clk edges; period/high_time are unchanged for clean inputs.
- Undefined: no filter, latency 3 edges, and 1-cycle pulses are measured.

Decomposition:
- Package pwm_pkg:
  - state enum (WAIT_RISE, MEAS_HIGH, MEAS_LOW, STUCK).
  - default W, and the saturation constant as all-ones of W.
- One natural sub-module: sync_edge. It holds the SYNC_STAGES synchronizer, the s_d flop, the rise/fall outputs, and the optional filter.

Test Plan:
- Reset with pwm_in toggling: all outputs 0 while rst=0; no valid in the cycle after release.
- Clock-aligned pwm_in high 8 / low 8, repeated 4 periods -> first period discarded; 3 valids, each period=16, high_time=8, valid on 3rd edge after each rise.
- Duty sweep, same period 20 with high 1, 5 and 19 -> high_time 1, 5, 19 and period 20 each. With PWM_GLITCH_FILTER_EN the high=1 pulses are ignored and no valid occurs until the input becomes clean.
- W=8, pwm_in held 1 for 300 cycles -> stuck=1 and level=1 at cnt=255; period/high_time hold. Then period 10 / high 3 -> stuck clears on the rise, next valid gives 10/3.
- en dropped mid-MEAS_LOW for 5 cycles, then raised -> no valid during the disable and outputs hold; first post-enable partial period discarded; next full period reported correctly.
- rst asserted asynchronously mid-MEAS_HIGH (not on a clk edge) -> outputs zero immediately, and measurement restarts in WAIT_RISE after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM capture block: default widths, saturation value and FSM encodings.
package pwm_pkg;

    localparam int unsigned PWM_W_DEFAULT = 16;
    localparam logic [PWM_W_DEFAULT-1:0] PWM_SAT_DEFAULT = {PWM_W_DEFAULT{1'b1}};

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t WAIT_RISE = 2'd0;
    localparam pwm_state_t MEAS_HIGH = 2'd1;
    localparam pwm_state_t MEAS_LOW  = 2'd2;
    localparam pwm_state_t STUCK     = 2'd3;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Synchronizes pwm_in and produces rise/fall strobes on the synchronized level.
// Defining PWM_GLITCH_FILTER_EN adds a 2-cycle agreement filter ahead of edge detection.
module pwm_capture_sync_edge
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= s;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
    logic filt_q;
    logic filt_d;

    // A new level is taken only once s and its delayed copy agree.
    always_comb begin
        filt_d = filt_q;
        if (s == s_d_q) begin
            filt_d = s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign rise = filt_d & ~filt_q;
    assign fall = ~filt_d & filt_q;
`else
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clk cycles, with valid strobe and stuck detection.
// Optional glitch filter in the edge detector is enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned W           = PWM_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pwm_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         stuck,
    output logic         level
);

    localparam logic [W-1:0] CNT_SAT = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic       s;
    logic       rise;
    logic       fall;
    pwm_state_t state;
    logic [W-1:0] cnt;
    logic [W-1:0] hcap;

    pwm_capture_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst),
        .pwm_in(pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_RISE;
            cnt       <= '0;
            hcap      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            level     <= 1'b0;
        end else begin
            level <= s;
            valid <= 1'b0;
            if (!en) begin
                state <= WAIT_RISE;
                cnt   <= '0;
                stuck <= 1'b0;
            end else begin
                // An awaited edge always takes priority over saturation.
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= MEAS_HIGH;
                        end else if (cnt == CNT_SAT) begin
                            stuck <= 1'b1;
                            state <= STUCK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            hcap  <= cnt;
                            cnt   <= cnt + 1'b1;
                            state <= MEAS_LOW;
                        end else if (cnt == CNT_SAT) begin
                            stuck <= 1'b1;
                            state <= STUCK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hcap;
                            valid     <= 1'b1;
                            cnt       <= CNT_ONE;
                            state     <= MEAS_HIGH;
                        end else if (cnt == CNT_SAT) begin
                            stuck <= 1'b1;
                            state <= STUCK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (rise) begin
                            stuck <= 1'b0;
                            cnt   <= CNT_ONE;
                            state <= MEAS_HIGH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (W=8 so saturation is reachable quickly).
module tb_pwm_capture;

    localparam int unsigned W = 8;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int EXP_LAT = 4;
    localparam int EXP_HOLD_H = 5;
`else
    localparam int EXP_LAT = 3;
    localparam int EXP_HOLD_H = 19;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b1;
    logic         pwm_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         stuck;
    logic         level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int vcnt = 0;
    int lp = -1;
    int lh = -1;
    int llat = -1;
    int vsnap;

    pwm_capture #(
        .W          (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pwm_in   (pwm_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .stuck    (stuck),
        .level    (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            lp   = int'(period);
            lh   = int'(high_time);
            llat = cyc - rise_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left just after a rising clock edge.
    task automatic drive(input int hi, input int lo);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        step(hi);
        pwm_in = 1'b0;
        step(lo);
    endtask

    initial begin
        // Reset held with pwm_in toggling.
        step(1);
        for (int i = 0; i < 6; i++) begin
            pwm_in = i[0];
            @(negedge clk);
            check("reset_outputs", {period, high_time, valid, stuck, level}, 0);
            @(posedge clk);
            #1;
        end
        pwm_in = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("valid_after_release", valid, 0);
        step(3);

        // 8 high / 8 low, four periods: first rise only starts measuring.
        vsnap = vcnt;
        repeat (4) drive(8, 8);
        check("p16_valid_count", vcnt - vsnap, 3);
        check("p16_period", lp, 16);
        check("p16_high", lh, 8);
        check("p16_latency", llat, EXP_LAT);

        // Duty sweep at period 20.
        vsnap = vcnt;
        repeat (2) drive(1, 19);
`ifdef PWM_GLITCH_FILTER_EN
        check("h1_filtered_no_valid", vcnt - vsnap, 0);
`else
        check("h1_valid_count", vcnt - vsnap, 2);
        check("h1_period", lp, 20);
        check("h1_high", lh, 1);
`endif
        repeat (2) drive(5, 15);
        check("h5_period", lp, 20);
        check("h5_high", lh, 5);
`ifndef PWM_GLITCH_FILTER_EN
        repeat (2) drive(19, 1);
        check("h19_period", lp, 20);
        check("h19_high", lh, 19);
`endif

        // Input held high long enough to saturate the 8-bit counter.
        pwm_in = 1'b1;
        step(10);
        vsnap = vcnt;
        step(290);
        check("stuck_set", stuck, 1);
        check("stuck_level_hi", level, 1);
        check("stuck_no_valid", vcnt - vsnap, 0);
        check("stuck_period_hold", period, 20);
        check("stuck_high_hold", high_time, EXP_HOLD_H);
        pwm_in = 1'b0;
        step(7);
        check("stuck_after_fall", stuck, 1);
        check("stuck_level_lo", level, 0);
        vsnap = vcnt;
        drive(3, 7);
        check("stuck_cleared", stuck, 0);
        check("stuck_clear_no_valid", vcnt - vsnap, 0);
        drive(3, 7);
        check("recover_valid_count", vcnt - vsnap, 1);
        check("recover_period", lp, 10);
        check("recover_high", lh, 3);

        // Enable dropped mid-low, re-raised while the input is high.
        drive(3, 0);
        step(2);
        en    = 1'b0;
        vsnap = vcnt;
        step(1);
        pwm_in = 1'b1;
        step(4);
        check("dis_no_valid", vcnt - vsnap, 0);
        check("dis_period_hold", period, 10);
        check("dis_high_hold", high_time, 3);
        check("dis_stuck", stuck, 0);
        en = 1'b1;
        step(2);
        pwm_in = 1'b0;
        step(6);
        drive(4, 6);
        check("reen_partial_discard", vcnt - vsnap, 0);
        drive(4, 6);
        check("reen_valid_count", vcnt - vsnap, 1);
        check("reen_period", lp, 10);
        check("reen_high", lh, 4);

        // Asynchronous reset between clock edges during the high phase.
        pwm_in = 1'b1;
        step(4);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_immediate", {period, high_time, valid, stuck, level}, 0);
        @(posedge clk);
        #1;
        pwm_in = 1'b0;
        check("async_reset_held", {period, high_time, valid, stuck, level}, 0);
        vsnap = vcnt;
        rst   = 1'b1;
        step(5);
        check("post_reset_period", period, 0);
        check("post_reset_high", high_time, 0);
        drive(6, 6);
        check("post_reset_first_rise", vcnt - vsnap, 0);
        drive(6, 6);
        check("post_reset_valid_count", vcnt - vsnap, 1);
        check("post_reset_period_meas", lp, 12);
        check("post_reset_high_meas", lh, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
